// File: rtl/delay_ram_scheduler.sv
// Shares one single-port synchronous delay RAM among N_REQ audio effects.
// Each requester gets one circular-buffer write and one delayed read per sample frame.
module delay_ram_scheduler #(
  parameter int N_REQ     = 2,
  parameter int DW        = 16,
  parameter int REGION_AW = 12,
  parameter int AW        = 16,
  parameter int RD_LAT    = 1
) (
  input  logic                      clk,
  input  logic                      ADCLRCK,
  input  logic                      frame_tick,
  input  logic                      clr_overrun,
  input  logic [N_REQ-1:0]          req_en,
  input  logic [N_REQ*DW-1:0]       wr_data,
  input  logic [N_REQ*REGION_AW-1:0] delay,
  output logic [N_REQ*DW-1:0]       rd_data,
  output logic [N_REQ-1:0]          rd_valid,
  output logic                      busy,
  output logic                      overrun,
  output logic [AW-1:0]             ram_addr,
  output logic [DW-1:0]             ram_d,
  output logic                      ram_we,
  input  logic [DW-1:0]             ram_q
);

  localparam int IW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WCW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int WAIT_LAST = (RD_LAT > 1) ? RD_LAT - 2 : 0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    READ    = 3'd2,
    WAIT    = 3'd3,
    CAPTURE = 3'd4
  } state_t;

  // Lowest enabled requester at or above start; MSB flags that one was found.
  function automatic logic [IW:0] pick_from(input logic [N_REQ-1:0] en, input int start);
    logic [IW:0] r;
    r = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      r = (en[i] && (i >= start)) ? {1'b1, IW'(i)} : r;
    end
    return r;
  endfunction

  function automatic logic [AW-1:0] region_addr(input logic [IW-1:0] id,
                                                input logic [REGION_AW-1:0] off);
    return AW'({id, off});
  endfunction

  state_t                 state_r, state_s;
  logic [IW-1:0]          idx_r, idx_s;
  logic [WCW-1:0]         wait_cnt_r, wait_cnt_s;
  logic                   cap_done_r, cap_done_s;
  logic                   busy_r, busy_s;
  logic                   overrun_r, overrun_s;
  logic                   ram_we_r, ram_we_s;
  logic [AW-1:0]          ram_addr_r, ram_addr_s;
  logic [DW-1:0]          ram_d_r, ram_d_s;
  logic                   accept_s, capture_s;
  logic [IW:0]            first_s, next_s;
  logic [N_REQ-1:0]       snap_en_r;
  logic [DW-1:0]          snap_data_r  [N_REQ];
  logic [REGION_AW-1:0]   snap_delay_r [N_REQ];
  logic [REGION_AW-1:0]   wr_ptr_r     [N_REQ];
  logic [N_REQ*DW-1:0]    rd_data_r;
  logic [N_REQ-1:0]       rd_valid_r;

  // Next-state and next RAM-port values; RAM outputs are registered one phase ahead.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    wait_cnt_s = wait_cnt_r;
    cap_done_s = cap_done_r;
    busy_s     = busy_r;
    ram_we_s   = 1'b0;
    ram_addr_s = ram_addr_r;
    ram_d_s    = ram_d_r;
    accept_s   = 1'b0;
    capture_s  = 1'b0;
    first_s    = pick_from(req_en, 0);
    next_s     = pick_from(snap_en_r, int'(idx_r) + 1);
    case (state_r)
      IDLE: begin
        if (frame_tick && first_s[IW]) begin
          // Snapshot is not yet visible, so the first write uses the live inputs.
          accept_s   = 1'b1;
          idx_s      = first_s[IW-1:0];
          busy_s     = 1'b1;
          state_s    = WRITE;
          ram_we_s   = 1'b1;
          ram_addr_s = region_addr(first_s[IW-1:0], wr_ptr_r[first_s[IW-1:0]]);
          ram_d_s    = wr_data[first_s[IW-1:0]*DW +: DW];
        end else begin
          busy_s = 1'b0;
        end
      end
      WRITE: begin
        state_s    = READ;
        ram_addr_s = region_addr(idx_r, wr_ptr_r[idx_r] - snap_delay_r[idx_r]);
      end
      READ: begin
        wait_cnt_s = '0;
        cap_done_s = 1'b0;
        state_s    = (RD_LAT > 1) ? WAIT : CAPTURE;
      end
      WAIT: begin
        if (wait_cnt_r == WCW'(WAIT_LAST)) begin
          state_s = CAPTURE;
        end else begin
          wait_cnt_s = wait_cnt_r + WCW'(1);
        end
      end
      CAPTURE: begin
        // First CAPTURE cycle samples ram_q; the second hands over to the next slot.
        if (!cap_done_r) begin
          capture_s  = 1'b1;
          cap_done_s = 1'b1;
        end else if (next_s[IW]) begin
          idx_s      = next_s[IW-1:0];
          state_s    = WRITE;
          ram_we_s   = 1'b1;
          ram_addr_s = region_addr(next_s[IW-1:0], wr_ptr_r[next_s[IW-1:0]]);
          ram_d_s    = snap_data_r[next_s[IW-1:0]];
        end else begin
          state_s = IDLE;
          busy_s  = 1'b0;
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
    overrun_s = (frame_tick && busy_r) ? 1'b1 : (clr_overrun ? 1'b0 : overrun_r);
  end

  // FSM state and registered RAM-port outputs.
  always_ff @(posedge clk or posedge ADCLRCK) begin
    if (ADCLRCK) begin
      state_r    <= IDLE;
      idx_r      <= '0;
      wait_cnt_r <= '0;
      cap_done_r <= 1'b0;
      busy_r     <= 1'b0;
      overrun_r  <= 1'b0;
      ram_we_r   <= 1'b0;
      ram_addr_r <= '0;
      ram_d_r    <= '0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      wait_cnt_r <= wait_cnt_s;
      cap_done_r <= cap_done_s;
      busy_r     <= busy_s;
      overrun_r  <= overrun_s;
      ram_we_r   <= ram_we_s;
      ram_addr_r <= ram_addr_s;
      ram_d_r    <= ram_d_s;
    end
  end

  // Frame snapshot so that input changes after acceptance do not disturb the frame.
  always_ff @(posedge clk or posedge ADCLRCK) begin
    if (ADCLRCK) begin
      snap_en_r <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        snap_data_r[i]  <= '0;
        snap_delay_r[i] <= '0;
      end
    end else if (accept_s) begin
      snap_en_r <= req_en;
      for (int i = 0; i < N_REQ; i++) begin
        snap_data_r[i]  <= wr_data[i*DW +: DW];
        snap_delay_r[i] <= delay[i*REGION_AW +: REGION_AW];
      end
    end
  end

  // Read-data capture and write-pointer advance at the end of each slot.
  always_ff @(posedge clk or posedge ADCLRCK) begin
    if (ADCLRCK) begin
      rd_data_r  <= '0;
      rd_valid_r <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        wr_ptr_r[i] <= '0;
      end
    end else begin
      rd_valid_r <= '0;
      if (capture_s) begin
        rd_data_r[idx_r*DW +: DW] <= ram_q;
        rd_valid_r[idx_r]         <= 1'b1;
        wr_ptr_r[idx_r]           <= wr_ptr_r[idx_r] + REGION_AW'(1);
      end
    end
  end

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign busy     = busy_r;
  assign overrun  = overrun_r;
  assign ram_addr = ram_addr_r;
  assign ram_d    = ram_d_r;
  assign ram_we   = ram_we_r;

  delay_ram_scheduler_chk #(.N_REQ(N_REQ)) u_chk (
    .clk        (clk),
    .ADCLRCK    (ADCLRCK),
    .frame_tick (frame_tick),
    .busy       (busy_r),
    .overrun    (overrun_r),
    .ram_we     (ram_we_r),
    .rd_valid   (rd_valid_r)
  );

endmodule

// Protocol invariants of the scheduler outputs.
module delay_ram_scheduler_chk #(
  parameter int N_REQ = 2
) (
  input logic             clk,
  input logic             ADCLRCK,
  input logic             frame_tick,
  input logic             busy,
  input logic             overrun,
  input logic             ram_we,
  input logic [N_REQ-1:0] rd_valid
);

  a_we_in_frame: assert property (@(posedge clk) disable iff (ADCLRCK) ram_we |-> busy)
    else $error("chk: ram_we outside a frame");

  a_one_valid: assert property (@(posedge clk) disable iff (ADCLRCK) $onehot0(rd_valid))
    else $error("chk: more than one rd_valid");

  a_overrun_set: assert property (@(posedge clk) disable iff (ADCLRCK)
                                  (frame_tick && busy) |=> overrun)
    else $error("chk: overrun not set");

endmodule
